// File: rtl/sr_ctrl_pkg.sv
// Shared types for the SR latch controller: FSM states, operation codes and
// the feedback-match helper used wherever a latch value is confirmed.
package sr_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PULSE  = 2'd1,
    SETTLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_SET  = 2'd1,
    OP_CLR  = 2'd2
  } op_t;

  // A latch is only confirmed when Q and Qn are complementary; (1,1)/(0,0) never match.
  function automatic logic fb_match(input logic q, input logic qn, input logic target);
    return (q == target) && (qn == !target);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first active request at or after ptr,
// returning it as a one-hot vector, a binary index and a valid flag.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IW-1:0]    idx,
  output logic             valid
);

  int cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = 0;
    for (int off = 0; off < N_REQ; off++) begin
      cand = (int'(ptr) + off) % N_REQ;
      if (!valid && req[cand]) begin
        valid     = 1'b1;
        idx       = IW'(cand);
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sr_latch_ctrl.sv
// Controller owning the S/R pins of one shared NOR SR latch: round-robin
// request arbitration, fixed-width S or R pulses, synchronised Q/Qn confirm.
//
//   state  | meaning
//   IDLE   | waiting for any active requester; arbitrate and decide op
//   PULSE  | holding S (set) or R (clear) high for PULSE_CYC cycles
//   SETTLE | S/R low; waiting for synced Q/Qn to reach the target, bounded
//   DONE   | one-cycle grant to the winner with error flags, back to IDLE
module sr_latch_ctrl
  import sr_ctrl_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int PULSE_CYC   = 2,
  parameter int TIMEOUT_CYC = 8,
  parameter int SYNC_STG    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req_set,
  input  logic [N_REQ-1:0] req_clr,
  output logic [N_REQ-1:0] grant,
  output logic             busy,
  output logic             latch_s,
  output logic             latch_r,
  input  logic             latch_q,
  input  logic             latch_qn,
  output logic             q_state,
  output logic             err_timeout,
  output logic             err_conflict
);

  localparam int IW = $clog2(N_REQ);
  localparam int PW = $clog2(PULSE_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int BW = $clog2(SYNC_STG + 1);
  localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

  state_t state_q, state_d;
  op_t    op_q, op_d;

  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [PW-1:0]    pulse_cnt_q, pulse_cnt_d;
  logic [TW-1:0]    settle_cnt_q, settle_cnt_d;
  logic [BW-1:0]    blank_cnt_q, blank_cnt_d;
  logic             latch_s_q, latch_s_d;
  logic             latch_r_q, latch_r_d;
  logic             q_state_q, q_state_d;
  logic             err_to_q, err_to_d;
  logic             err_cf_q, err_cf_d;
  logic [N_REQ-1:0] grant_q, grant_d;

  logic [SYNC_STG-1:0] q_sync_q, q_sync_d;
  logic [SYNC_STG-1:0] qn_sync_q, qn_sync_d;
  logic                q_fb, qn_fb;

  logic [N_REQ-1:0] req_act;
  logic [N_REQ-1:0] arb_gnt;
  logic [IW-1:0]    arb_idx;
  logic             arb_valid;
  logic             target;

  assign req_act = req_set | req_clr;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_arb (
    .req   (req_act),
    .ptr   (ptr_q),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  assign q_sync_d  = {q_sync_q[SYNC_STG-2:0], latch_q};
  assign qn_sync_d = {qn_sync_q[SYNC_STG-2:0], latch_qn};
  assign q_fb      = q_sync_q[SYNC_STG-1];
  assign qn_fb     = qn_sync_q[SYNC_STG-1];

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    ptr_d        = ptr_q;
    idx_d        = idx_q;
    pulse_cnt_d  = pulse_cnt_q;
    settle_cnt_d = settle_cnt_q;
    blank_cnt_d  = blank_cnt_q;
    latch_s_d    = 1'b0;
    latch_r_d    = 1'b0;
    q_state_d    = q_state_q;
    err_to_d     = 1'b0;
    err_cf_d     = 1'b0;
    grant_d      = '0;
    target       = (op_q == OP_SET);

    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          idx_d  = arb_idx;
          ptr_d  = (arb_idx == IW'(N_REQ - 1)) ? '0 : arb_idx + IW'(1);
          target = req_set[arb_idx];
          if (req_set[arb_idx] && req_clr[arb_idx]) begin
            op_d     = OP_NONE;
            state_d  = DONE;
            grant_d  = arb_gnt;
            err_cf_d = 1'b1;
          end else if (fb_match(q_fb, qn_fb, target)) begin
            op_d      = target ? OP_SET : OP_CLR;
            state_d   = DONE;
            grant_d   = arb_gnt;
            q_state_d = target;
          end else begin
            op_d        = target ? OP_SET : OP_CLR;
            state_d     = PULSE;
            pulse_cnt_d = PW'(PULSE_CYC - 1);
            latch_s_d   = target;
            latch_r_d   = !target;
          end
        end
      end

      PULSE: begin
        if (pulse_cnt_q == '0) begin
          state_d      = SETTLE;
          settle_cnt_d = TW'(TIMEOUT_CYC - 1);
          blank_cnt_d  = BW'(SYNC_STG);
        end else begin
          pulse_cnt_d = pulse_cnt_q - PW'(1);
          latch_s_d   = (op_q == OP_SET);
          latch_r_d   = (op_q == OP_CLR);
        end
      end

      // Feedback sampled while S/R was still high is still in the synchroniser
      // for SYNC_STG cycles; it is not trusted until it has flushed through.
      SETTLE: begin
        if (blank_cnt_q != '0) begin
          blank_cnt_d = blank_cnt_q - BW'(1);
        end
        if ((blank_cnt_q == '0) && fb_match(q_fb, qn_fb, target)) begin
          state_d   = DONE;
          grant_d   = ONE_HOT0 << idx_q;
          q_state_d = target;
        end else if (settle_cnt_q == '0) begin
          state_d  = DONE;
          grant_d  = ONE_HOT0 << idx_q;
          err_to_d = 1'b1;
        end else begin
          settle_cnt_d = settle_cnt_q - TW'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      op_q         <= OP_NONE;
      ptr_q        <= '0;
      idx_q        <= '0;
      pulse_cnt_q  <= '0;
      settle_cnt_q <= '0;
      blank_cnt_q  <= '0;
      latch_s_q    <= 1'b0;
      latch_r_q    <= 1'b0;
      q_state_q    <= 1'b0;
      err_to_q     <= 1'b0;
      err_cf_q     <= 1'b0;
      grant_q      <= '0;
      q_sync_q     <= '0;
      qn_sync_q    <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      ptr_q        <= ptr_d;
      idx_q        <= idx_d;
      pulse_cnt_q  <= pulse_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      blank_cnt_q  <= blank_cnt_d;
      latch_s_q    <= latch_s_d;
      latch_r_q    <= latch_r_d;
      q_state_q    <= q_state_d;
      err_to_q     <= err_to_d;
      err_cf_q     <= err_cf_d;
      grant_q      <= grant_d;
      q_sync_q     <= q_sync_d;
      qn_sync_q    <= qn_sync_d;
    end
  end

  assign grant        = grant_q;
  assign busy         = (state_q != IDLE);
  assign latch_s      = latch_s_q;
  assign latch_r      = latch_r_q;
  assign q_state      = q_state_q;
  assign err_timeout  = err_to_q;
  assign err_conflict = err_cf_q;

endmodule
